// File: rtl/params_pkg.sv
// Shared fetch/decode widths and the queue entry layout.
// Imported by the fetch queue and by decode.
package params_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// First-word-fall-through instruction queue between fetch and decode.
// hold rises one slot early so the in-flight fetch always has room.
module fetch_queue
   import params_pkg::fq_entry_t;
#(
   parameter int DEPTH   = 4,
   parameter int ADDR_W  = params_pkg::ADDR_W,
   parameter int INSTR_W = params_pkg::INSTR_W,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [ADDR_W-1:0]  in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               flush,
   output logic               hold,
   output logic               out_valid,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [INSTR_W-1:0] out_instr,
   input  logic               out_ready,
   output logic [CNT_W-1:0]   count,
   output logic               ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] HIGH = CNT_W'(DEPTH - 1);

   fq_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rp;
   logic [PTR_W-1:0] wp;
   logic             full;
   logic             pop;
   logic             push;
   logic             drop;

   assign full = (count == FULL);
   assign pop  = out_valid & out_ready;
   assign push = in_valid & (~full | pop);
   assign drop = in_valid & full & ~pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rp    <= '0;
         wp    <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else if (flush) begin
         // redirect wins: same-cycle push/pop/drop are all void
         rp    <= '0;
         wp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + PTR_W'(1);
         if (pop)  rp <= rp + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (drop) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push & ~flush) begin
         mem[wp] <= '{pc: in_pc, instr: in_instr};
      end
   end

   assign out_valid = (count != '0);
   assign hold      = (count >= HIGH);
   assign out_pc    = mem[rp].pc;
   assign out_instr = mem[rp].instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed plan plus random traffic.
// Driver predicts accepted pushes; monitor checks head and occupancy.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int IW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic [AW-1:0] in_pc = '0;
   logic [IW-1:0] in_instr = '0;
   logic          flush = 1'b0;
   logic          hold;
   logic          out_valid;
   logic [AW-1:0] out_pc;
   logic [IW-1:0] out_instr;
   logic          out_ready = 1'b0;
   logic [2:0]    count;
   logic          ovf;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
      .flush(flush), .hold(hold),
      .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
      .out_ready(out_ready), .count(count), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // reference contents of the queue, oldest first
   logic [63:0] exp_q[$];
   bit          ovf_m = 0;
   bit          pend_push = 0;
   bit          pend_flush = 0;
   bit          pend_drop = 0;
   logic [63:0] pend_e = '0;
   int          pops_seen = 0;
   bit          wrap_phase = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: samples between edges
   always @(negedge clk) begin
      chk("count", 64'(count), 64'(exp_q.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("hold", 64'(hold), 64'(exp_q.size() >= DEPTH - 1));
      chk("ovf", 64'(ovf), 64'(ovf_m));
      if (exp_q.size() != 0)
         chk("head", {out_pc, out_instr}, exp_q[0]);
      if (wrap_phase)
         chk("wrap_count_le1", 64'(count <= 3'd1), 64'd1);
      if (rst && out_ready && !flush && exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         pops_seen++;
      end
   end

   task automatic apply_pending();
      if (pend_flush) exp_q.delete();
      else begin
         if (pend_push) exp_q.push_back(pend_e);
         if (pend_drop) ovf_m = 1;
      end
      pend_flush = 0;
      pend_push  = 0;
      pend_drop  = 0;
   endtask

   task automatic step(bit iv, logic [AW-1:0] pc, bit rdy, bit fl);
      logic [IW-1:0] ins;
      int sz;
      bit pop;
      @(posedge clk);
      #1;
      apply_pending();
      ins = $urandom;
      in_valid  = iv;
      in_pc     = pc;
      in_instr  = ins;
      out_ready = rdy;
      flush     = fl;
      sz  = exp_q.size();
      pop = rdy && sz != 0;
      if (fl) pend_flush = 1;
      else if (iv && (sz < DEPTH || pop)) begin
         pend_push = 1;
         pend_e    = {pc, ins};
      end else if (iv) pend_drop = 1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      flush = 1'b0;
      exp_q.delete();
      ovf_m = 0;
      pend_flush = 0;
      pend_push = 0;
      pend_drop = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int base;
      // reset held for two cycles, then first push accepted
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      step(1, 32'h100, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // fill to three, then drain in order
      step(1, 32'h00, 0, 0);
      step(1, 32'h04, 0, 0);
      step(1, 32'h08, 0, 0);
      step(0, 0, 0, 0);
      base = pops_seen;
      repeat (4) step(0, 0, 1, 0);
      chk("drain_pops", 64'(pops_seen - base), 64'd3);

      // full with simultaneous push and pop
      for (int i = 0; i < 4; i++) step(1, 32'h40 + 4 * i, 0, 0);
      step(1, 32'h50, 1, 0);
      step(0, 0, 0, 0);

      // overflow: drop while full, sticky through drain
      step(1, 32'h60, 0, 0);
      step(0, 0, 0, 0);
      repeat (5) step(0, 0, 1, 0);
      chk("ovf_sticky", 64'(ovf), 64'd1);

      // flush at count 3 with push and pop pending
      for (int i = 0; i < 3; i++) step(1, 32'h80 + 4 * i, 0, 0);
      step(1, 32'h8c, 1, 1);
      step(1, 32'h90, 0, 0);
      step(0, 0, 0, 0);
      repeat (2) step(0, 0, 1, 0);

      // pointer wrap: stream ten pushes with decode always ready
      wrap_phase = 1;
      base = pops_seen;
      for (int i = 0; i < 10; i++) step(1, 4 * i, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      wrap_phase = 0;
      chk("wrap_pops", 64'(pops_seen - base), 64'd10);

      // random traffic with one mid-run reset
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         step(($urandom_range(0, 9) < 7), $urandom & 32'hffff_fffc,
              ($urandom_range(0, 9) < 5), ($urandom_range(0, 29) == 0));
      end
      repeat (6) step(0, 0, 1, 0);
      @(posedge clk);
      #1;
      apply_pending();
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the instruction-fetch stage and decode. It captures each `{pc, instr}` pair that fetch marks valid and buffers it in a small first-word-fall-through FIFO. It presents the oldest entry to decode over a valid/ready handshake. Backpressure goes to fetch through `hold`, and a redirect empties the queue through `flush`.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `ADDR_W`, `params_pkg::ADDR_W`: PC width.
- `INSTR_W`, `params_pkg::INSTR_W`: instruction width.
- `CNT_W`, `$clog2(DEPTH+1)`: occupancy width (derived localparam).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  fetch has a latched instruction this cycle.
- `in_pc`  in  ADDR_W  PC of that instruction.
- `in_instr`  in  INSTR_W  instruction word.
- `flush`  in  1  discard all entries (branch/redirect).
- `hold`  out  1  to fetch: stop issuing new requests.
- `out_valid`  out  1  head entry valid to decode.
- `out_pc`  out  ADDR_W  head PC.
- `out_instr`  out  INSTR_W  head instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `count`  out  CNT_W  current occupancy, 0..DEPTH.
- `ovf`  out  1  sticky flag: a push was dropped while full.

## Operation
- Storage: DEPTH entries, read pointer `rp`, write pointer `wp`, `count`. Each pointer is `$clog2(DEPTH)` bits and wraps naturally modulo DEPTH.
- `pop` = `out_valid & out_ready`.
- `push` = `in_valid & (count < DEPTH | pop)`. A write into a full queue is allowed only when a pop happens in the same cycle.
- Push writes `{in_pc, in_instr}` at `wp`, then `wp++`. Pop advances `rp++`.
- `count` next value:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on both or neither.
- Dropped push: if `in_valid & count==DEPTH & !pop`, the entry is discarded and `ovf` sets to 1. `ovf` is cleared only by reset.
- Flush has priority over everything:
  - `rp`, `wp` and `count` go to 0.
  - Any same-cycle push and pop are ignored. The pop is not counted as consumed, and `ovf` is not set by that cycle.
- `out_valid = (count != 0)`. `out_pc`/`out_instr` come from the entry at `rp`. All outputs are driven from registers; there is no combinational path from `in_*` to `out_*`.
- `hold = (count >= DEPTH-1)`. This one-slot margin absorbs the single fetch instruction already in flight when hold rises. With a correct fetch, `ovf` never sets.
- Reset values: `count`=0, `rp`=`wp`=0, `out_valid`=0, `hold`=0, `ovf`=0. `out_pc`/`out_instr` read the entry at index 0, which is cleared to 0 on reset. Storage contents may otherwise stay unreset.

## Timing
- Push at edge N makes the entry visible at the head after edge N, provided the queue was empty: `out_valid`=1 in cycle N+1. Latency is 1 cycle.
- Pop at edge N: the next entry (or `out_valid`=0) appears after edge N.
- `hold` follows `count` with zero extra latency after the edge that changes `count`.
- Flush at edge N: `out_valid`=0 and `hold`=0 in cycle N+1. A push arriving in cycle N+1 is accepted normally.
- Reset asserted mid-operation clears the queue asynchronously. The first push is accepted on the first edge after `rst` deasserts.

## Structure
- `params_pkg` holds `ADDR_W` and `INSTR_W`, plus a new `typedef struct packed { logic [ADDR_W-1:0] pc; logic [INSTR_W-1:0] instr; } fq_entry_t;` shared with decode.
- Single module; the pointer/count logic and the memory array stay inline, with no sub-module.

## Test plan
All with DEPTH=4.
- Reset: hold `rst`=0 for 2 cycles → `count`=0, `out_valid`=0, `hold`=0, `ovf`=0; release it → first push is accepted.
- Fill/drain:
  - Push PCs 0x00, 0x04, 0x08 with `out_ready`=0 → `count`=3, `hold`=1, head `out_pc`=0x00.
  - Then set `out_ready`=1 → pops occur in order 0x00, 0x04, 0x08; `hold` drops when `count` reaches 2.
- Full with simultaneous push/pop: at `count`=4, drive `in_valid`=1 and `out_ready`=1 → `count` stays 4, head advances, new entry lands at the tail, `ovf`=0.
- Overflow: at `count`=4, drive `in_valid`=1 and `out_ready`=0 → entry dropped, `count`=4, `ovf`=1 and it stays 1 after the queue drains.
- Flush: at `count`=3 with `in_valid`=1 and `out_ready`=1 in the same cycle, assert `flush` → next cycle `count`=0, `out_valid`=0, `hold`=0; a push the cycle after gives `count`=1 with that PC at the head.
- Pointer wrap: stream 10 pushes of PCs 0x00..0x24 (step 4) with `out_ready`=1 throughout → decode receives all 10 in order, no gaps, `count` ≤ 1.
